// File: rtl/fabric_pkg.sv
// Shared definitions for the CLB fabric: sequencer state encoding and the
// bitstream geometry derived from the CLB's LUT structure.
package fabric_pkg;

  localparam int LUT_WIDTH  = 4;
  localparam int SIG_TYPE_W = 2;
  localparam int SIG_IDX_W  = 8;
  localparam int TT_BITS    = 1 << LUT_WIDTH;

  // One serial beat per bit; each CLB segment is its input selects plus truth table.
  localparam int DEFAULT_DATA_W        = 1;
  localparam int DEFAULT_BEATS_PER_CLB = LUT_WIDTH * (SIG_TYPE_W + SIG_IDX_W) + TT_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_START,
    ST_CFG_STREAM,
    ST_DONE,
    ST_RUN,
    ST_ERROR
  } t_seq_state;

endpackage

// File: rtl/stream_demux.sv
// Combinational one-to-many valid/ready router: steers the upstream valid to the
// selected CLB and returns that CLB's ready upstream.
module stream_demux #(
  parameter int NUM_CLBS  = 4,
  parameter int CLB_IDX_W = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1
) (
  input  logic                 en,
  input  logic [CLB_IDX_W-1:0] sel,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [NUM_CLBS-1:0]  m_tvalid,
  input  logic [NUM_CLBS-1:0]  m_tready
);

  always_comb begin
    m_tvalid = '0;
    s_tready = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_CLBS; k++) begin
        m_tvalid[k] = s_tvalid && (sel == CLB_IDX_W'(k));
      end
      s_tready = m_tready[sel];
    end
  end

endmodule

// File: rtl/fabric_cfg_sequencer.sv
// Configuration and run controller for the CLB array: splits one serial bitstream
// into per-CLB segments, checks its framing, and gates the global run signal.
module fabric_cfg_sequencer
  import fabric_pkg::*;
#(
  parameter int NUM_CLBS      = 4,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int BEATS_PER_CLB = DEFAULT_BEATS_PER_CLB,
  parameter int CLB_IDX_W     = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1,
  parameter int BEAT_CNT_W    = (BEATS_PER_CLB > 1) ? $clog2(BEATS_PER_CLB) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_cfg,
  input  logic                 run_en,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic                 s_tlast,
  output logic [NUM_CLBS-1:0]  clb_cfg,
  output logic [NUM_CLBS-1:0]  m_tvalid,
  input  logic [NUM_CLBS-1:0]  m_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic                 m_tlast,
  output logic                 run,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 busy,
  output logic [CLB_IDX_W-1:0] clb_idx
);

  t_seq_state            state_q, state_d;
  logic [CLB_IDX_W-1:0]  clb_idx_q, clb_idx_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  cfg_done_q, cfg_done_d;
  logic                  cfg_err_q, cfg_err_d;

  logic stream_active;
  logic xfer;
  logic seg_last;
  logic clb_last;

  assign stream_active = (state_q == ST_CFG_STREAM);
  assign seg_last      = (beat_cnt_q == BEAT_CNT_W'(BEATS_PER_CLB - 1));
  assign clb_last      = (clb_idx_q == CLB_IDX_W'(NUM_CLBS - 1));
  assign xfer          = s_tvalid && s_tready;

  stream_demux #(
    .NUM_CLBS  (NUM_CLBS),
    .CLB_IDX_W (CLB_IDX_W)
  ) u_demux (
    .en       (stream_active),
    .sel      (clb_idx_q),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  always_comb begin
    state_d    = state_q;
    clb_idx_d  = clb_idx_q;
    beat_cnt_d = beat_cnt_q;
    cfg_done_d = cfg_done_q;
    cfg_err_d  = cfg_err_q;
    clb_cfg    = '0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_cfg) begin
          state_d    = ST_CFG_START;
          clb_idx_d  = '0;
          beat_cnt_d = '0;
          cfg_done_d = 1'b0;
          cfg_err_d  = 1'b0;
        end else if ((state_q == ST_DONE) && run_en) begin
          state_d = ST_RUN;
        end
      end

      ST_CFG_START: begin
        clb_cfg[clb_idx_q] = 1'b1;
        state_d            = ST_CFG_STREAM;
      end

      // A beat carrying tlast is forwarded even when misplaced; the error takes effect after it.
      ST_CFG_STREAM: begin
        if (xfer) begin
          if (seg_last && clb_last) begin
            beat_cnt_d = '0;
            if (s_tlast) begin
              state_d    = ST_DONE;
              cfg_done_d = 1'b1;
            end else begin
              state_d   = ST_ERROR;
              cfg_err_d = 1'b1;
            end
          end else if (s_tlast) begin
            state_d   = ST_ERROR;
            cfg_err_d = 1'b1;
          end else if (seg_last) begin
            beat_cnt_d = '0;
            clb_idx_d  = clb_idx_q + CLB_IDX_W'(1);
            state_d    = ST_CFG_START;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end
        end
      end

      ST_RUN: begin
        if (!run_en) begin
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clb_idx_q  <= '0;
      beat_cnt_q <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clb_idx_q  <= clb_idx_d;
      beat_cnt_q <= beat_cnt_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign m_tdata  = s_tdata;
  assign m_tlast  = stream_active && seg_last;
  assign run      = (state_q == ST_RUN);
  assign busy     = (state_q == ST_CFG_START) || stream_active;
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign clb_idx  = clb_idx_q;

endmodule

// File: doc/fabric_cfg_sequencer.md
Name: fabric_cfg_sequencer

Overview:
Top-level configuration and run controller for the CLB array. Accepts one serial configuration bitstream and routes it in fixed-size segments to each CLB in turn. For each CLB it pulses that CLB's `cfg` and forwards exactly its segment. Once the array is configured, it gates the global `run` signal and flags bitstream framing errors (misplaced or missing `tlast`).

Parameters:
NUM_CLBS, 4, number of CLBs sequenced, configured in index order 0..NUM_CLBS-1
DATA_W, 1, stream data width per beat (matches CLB bitstream beat width)
BEATS_PER_CLB, 56, beats per CLB segment (4 LUT inputs x (2 type + 8 index) + 16 truth-table bits)
CLB_IDX_W, max(1,$clog2(NUM_CLBS)), width of CLB index
BEAT_CNT_W, max(1,$clog2(BEATS_PER_CLB)), width of beat counter

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
start_cfg  in  1  level/pulse request to (re)configure whole array
run_en  in  1  request to run configured fabric
s_tvalid  in  1  upstream bitstream valid
s_tready  out  1  upstream ready
s_tdata  in  DATA_W  upstream data
s_tlast  in  1  marks final beat of entire bitstream
clb_cfg  out  NUM_CLBS  one-hot, single-cycle cfg pulse to addressed CLB
m_tvalid  out  NUM_CLBS  per-CLB stream valid
m_tready  in  NUM_CLBS  per-CLB stream ready
m_tdata  out  DATA_W  shared stream data (= s_tdata)
m_tlast  out  1  high on last beat of each CLB segment
run  out  1  global run to all CLBs
cfg_done  out  1  array fully configured, no error
cfg_err  out  1  framing error latched
busy  out  1  configuration in progress
clb_idx  out  CLB_IDX_W  CLB currently addressed

Behaviour:
- Reset (async, rst=1) state:
  - State IDLE; clb_idx=0; beat_cnt=0.
  - All outputs 0: s_tready, clb_cfg, m_tvalid, m_tlast, run, cfg_done, cfg_err, busy.
- States: IDLE, CFG_START, CFG_STREAM, DONE, RUN, ERROR.
- IDLE / DONE / ERROR:
  - start_cfg=1 -> CFG_START; clb_idx<=0, beat_cnt<=0, cfg_err<=0, cfg_done<=0.
  - start_cfg has priority over run_en.
- CFG_START:
  - clb_cfg[clb_idx]=1 for exactly this cycle.
  - Unconditionally -> CFG_STREAM next cycle.
  - busy=1.
- CFG_STREAM:
  - m_tvalid[k] = s_tvalid && (k==clb_idx); all other bits 0.
  - s_tready = m_tready[clb_idx]; m_tdata = s_tdata.
  - m_tlast = (beat_cnt==BEATS_PER_CLB-1).
  - Beat transfers when s_tvalid && s_tready; beat_cnt increments per transfer.
  - busy=1. Zero added latency, fully combinational routing.
- Segment end (transfer with beat_cnt==BEATS_PER_CLB-1):
  - beat_cnt<=0.
  - If clb_idx<NUM_CLBS-1: clb_idx++, -> CFG_START.
  - Else -> DONE, cfg_done<=1.
- Framing checks, evaluated only on transferred beats:
  - s_tlast=1 on any beat other than global last -> ERROR, cfg_err<=1. That beat is still forwarded.
  - Global last beat with s_tlast=0 -> ERROR, cfg_err<=1.
  - ERROR holds clb_idx; s_tready=0, run=0, cfg_done=0.
- start_cfg during CFG_START/CFG_STREAM: ignored.
- DONE:
  - run_en=1 -> RUN.
  - s_tready=0; extra upstream beats are not consumed.
- RUN:
  - run=1 combinationally from state.
  - run_en=0 -> DONE (run low next cycle).
  - start_cfg ignored while in RUN; run_en must drop first.
- Outside CFG_STREAM: s_tready=0, m_tvalid=0, m_tlast=0.
- Reset mid-stream: immediate return to IDLE; configuration is lost and must be restarted.
- Width rules:
  - beat_cnt compares against BEATS_PER_CLB-1 cast to BEAT_CNT_W.
  - clb_idx never exceeds NUM_CLBS-1; no wrap.

Decomposition:
- Shared package fabric_pkg holds:
  - t_seq_state enum.
  - Default localparams for DATA_W and BEATS_PER_CLB, derived from the CLB's LUT_WIDTH and signal type/index widths, so the CLB and sequencer stay in sync.
- One natural sub-module: stream_demux, the combinational one-to-NUM_CLBS valid/ready router selected by clb_idx. The FSM and counters stay in fabric_cfg_sequencer.

Test Plan:
- Nominal configuration, NUM_CLBS=2, BEATS_PER_CLB=3, always ready:
  - Stimulus: start_cfg pulse, then 6 beats with tlast on beat 6.
  - Required: clb_cfg=01 for one cycle, m_tvalid[0] for beats 1-3 with m_tlast on beat 3, clb_cfg=10, m_tvalid[1] for beats 4-6, then cfg_done=1, cfg_err=0.
- Backpressure:
  - Stimulus: m_tready[1] toggling 1010 during segment 1.
  - Required: s_tready mirrors m_tready[1]; beat_cnt advances only on handshakes; no beat is lost or duplicated; cfg_done after the 6th transfer.
- Early tlast:
  - Stimulus: s_tlast on beat 2.
  - Required: beat 2 forwarded, then cfg_err=1, s_tready=0, cfg_done=0. A subsequent start_cfg clears cfg_err and restarts at clb_idx=0.
- Missing tlast:
  - Stimulus: beat 6 sent with tlast=0.
  - Required: cfg_err=1, no cfg_done; run_en=1 leaves run=0.
- Run gating:
  - Stimulus: after DONE, run_en=1 for 5 cycles, start_cfg pulsed mid-run, then run_en=0.
  - Required: run high 5 cycles starting one cycle after run_en rises; start_cfg ignored; state returns to DONE with cfg_done=1.
- Async reset:
  - Stimulus: rst asserted mid-segment-1 between clock edges.
  - Required: all outputs 0 immediately, without waiting for a clock edge; after release, a full start_cfg sequence completes normally.
